// File: rtl/line_event_encoder.sv
// Captures falling edges on an active-low 8-line bus and emits one 3-bit line code per event, lowest index first.
// Latency: line fall to valid is 2 cycles; sustained drain of 1 code per cycle while ready is held high.
// Backpressure: code and valid hold while ready=0, and new events keep accumulating in pending.
module line_event_encoder (
    input  logic       clk,
    input  logic       rst,
    input  logic [0:7] y_n,
    input  logic       en,
    output logic [2:0] code,
    output logic       valid,
    input  logic       ready,
    output logic [0:7] pending,
    output logic       overflow
);

    logic [0:7] y_q;
    logic [0:7] event_vec;
    logic [0:7] load_mask;
    logic [0:7] pending_nxt;
    logic [2:0] sel_idx;
    logic       slot_free;
    logic       do_load;
    logic       lost_event;

    assign event_vec = {8{en}} & y_q & ~y_n;
    assign slot_free = ~valid | ready;
    assign do_load   = slot_free & (|pending);

    always_comb begin
        sel_idx = 3'd0;
        for (int k = 7; k >= 0; k--) begin
            if (pending[k]) begin
                sel_idx = 3'(k);
            end
        end
    end

    always_comb begin
        load_mask = '0;
        if (do_load) begin
            load_mask[sel_idx] = 1'b1;
        end
    end

    // A fresh event on the line being loaded re-arms it instead of counting as lost.
    assign pending_nxt = (pending & ~load_mask) | event_vec;
    assign lost_event  = |(event_vec & pending & ~load_mask);

    always_ff @(posedge clk) begin
        y_q <= y_n;
        if (rst) begin
            pending  <= '0;
            valid    <= 1'b0;
            code     <= 3'd0;
            overflow <= 1'b0;
        end else begin
            pending <= pending_nxt;
            if (lost_event) begin
                overflow <= 1'b1;
            end
            if (slot_free) begin
                valid <= do_load;
                if (do_load) begin
                    code <= sel_idx;
                end
            end
        end
    end

endmodule

// File: tb/tb_line_event_encoder.sv
// Directed bench for line_event_encoder; inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_line_event_encoder;

    logic       clk = 1'b0;
    logic       rst;
    logic [0:7] y_n;
    logic       en;
    logic [2:0] code;
    logic       valid;
    logic       ready;
    logic [0:7] pending;
    logic       overflow;

    int checks = 0;
    int errors = 0;

    line_event_encoder dut (
        .clk      (clk),
        .rst      (rst),
        .y_n      (y_n),
        .en       (en),
        .code     (code),
        .valid    (valid),
        .ready    (ready),
        .pending  (pending),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] line(input int k);
        logic [7:0] one;
        one = 8'h80;
        return one >> k;
    endfunction

    initial begin
        rst = 1'b1; y_n = 8'hFF; en = 1'b1; ready = 1'b1;
        #1;
        step(2);
        chk("rst_pending", 32'(pending), 32'h00);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_code", 32'(code), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);

        // single event on line 5
        rst = 1'b0; step(1);
        y_n = 8'hFB; step(1);
        chk("l5_pending", 32'(pending), 32'h04);
        chk("l5_valid_early", 32'(valid), 32'd0);
        step(1);
        chk("l5_valid", 32'(valid), 32'd1);
        chk("l5_code", 32'(code), 32'd5);
        chk("l5_pending_clr", 32'(pending), 32'h00);
        y_n = 8'hFF; step(1);
        chk("l5_drained", 32'(valid), 32'd0);
        chk("l5_overflow", 32'(overflow), 32'd0);
        step(1);

        // lines 0,3,7 together, ordered drain
        y_n = 8'h6E; step(1);
        chk("multi_pending", 32'(pending), 32'h91);
        step(1);
        chk("multi_c0", 32'({valid, code}), 32'({1'b1, 3'd0}));
        step(1);
        chk("multi_c3", 32'({valid, code}), 32'({1'b1, 3'd3}));
        step(1);
        chk("multi_c7", 32'({valid, code}), 32'({1'b1, 3'd7}));
        step(1);
        chk("multi_end_valid", 32'(valid), 32'd0);
        chk("multi_end_pending", 32'(pending), 32'h00);
        y_n = 8'hFF; step(1);

        // backpressure: line 2 then line 6 with ready low
        ready = 1'b0;
        y_n = 8'hDF; step(2);
        chk("bp_c2", 32'({valid, code}), 32'({1'b1, 3'd2}));
        y_n = 8'hDD; step(2);
        chk("bp_hold", 32'({valid, code}), 32'({1'b1, 3'd2}));
        chk("bp_pending6", 32'(pending), 32'h02);
        ready = 1'b1; step(1);
        chk("bp_c6", 32'({valid, code}), 32'({1'b1, 3'd6}));
        step(1);
        chk("bp_drained", 32'(valid), 32'd0);
        y_n = 8'hFF; step(1);

        // overflow: line 4 re-falls while already pending behind a held code
        ready = 1'b0;
        y_n = 8'h7F; step(2);
        y_n = 8'h77; step(1);
        chk("ov_pending4", 32'(pending), 32'h08);
        y_n = 8'h7F; step(1);
        y_n = 8'h77; step(1);
        chk("ov_flag", 32'(overflow), 32'd1);
        chk("ov_pending_kept", 32'(pending), 32'h08);
        ready = 1'b1; step(1);
        chk("ov_c4", 32'({valid, code}), 32'({1'b1, 3'd4}));
        step(1);
        chk("ov_no_dup", 32'({valid, pending}), 32'h000);
        chk("ov_sticky", 32'(overflow), 32'd1);
        y_n = 8'hFF; rst = 1'b1; step(1);
        rst = 1'b0;
        chk("ov_cleared", 32'(overflow), 32'd0);
        step(1);

        // set wins: line 1 falls again on the edge it is loaded
        ready = 1'b0;
        y_n = 8'h7F; step(2);
        y_n = 8'h3F; step(1);
        chk("sw_pending1", 32'(pending), 32'h40);
        y_n = 8'h7F; step(1);
        y_n = 8'h3F; ready = 1'b1; step(1);
        chk("sw_c1", 32'({valid, code}), 32'({1'b1, 3'd1}));
        chk("sw_pending_kept", 32'(pending), 32'h40);
        chk("sw_no_overflow", 32'(overflow), 32'd0);
        step(1);
        chk("sw_c1_again", 32'({valid, code}), 32'({1'b1, 3'd1}));
        chk("sw_pending_clr", 32'(pending), 32'h00);
        step(1);
        chk("sw_drained", 32'(valid), 32'd0);
        y_n = 8'hFF; step(1);

        // enable gating
        en = 1'b0;
        y_n = 8'hEF; step(2);
        chk("en_off", 32'({valid, pending}), 32'h000);
        en = 1'b1; step(2);
        chk("en_reenable", 32'({valid, pending}), 32'h000);
        y_n = 8'hFF; step(1);

        // line 6 held low through reset
        y_n = 8'hFD; rst = 1'b1; step(1);
        rst = 1'b0; step(2);
        chk("rst_held_low", 32'({valid, pending}), 32'h000);
        y_n = 8'hFF; step(1);

        // reset discards pending events and the held code
        ready = 1'b0;
        y_n = 8'h99; step(2);
        chk("rstmid_code", 32'({valid, code}), 32'({1'b1, 3'd1}));
        chk("rstmid_pending", 32'(pending), 32'h26);
        rst = 1'b1; step(1);
        rst = 1'b0; y_n = 8'hFF;
        chk("rstmid_pending_clr", 32'(pending), 32'h00);
        chk("rstmid_valid_clr", 32'(valid), 32'd0);
        chk("rstmid_code_clr", 32'(code), 32'd0);
        step(1);

        // round trip through an active-low 3-to-8 decoder
        ready = 1'b1;
        for (int v = 0; v < 8; v++) begin
            y_n = ~line(v); step(2);
            chk($sformatf("rt_%0d", v), 32'({valid, code}), 32'({1'b1, 3'(v)}));
            y_n = 8'hFF; step(2);
        end
        chk("rt_idle", 32'(valid), 32'd0);
        chk("rt_overflow", 32'(overflow), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
